// File: rtl/time_overlay_render.sv
// Renders the latched BCD time as "HH:MM:SS" into the frame buffer from character-ROM glyphs.
// Define TIME_OVERLAY_OPAQUE_EN to also paint glyph-0 pixels with BG_COLOR (solid box).
module time_overlay_render #(
   parameter int unsigned FB_W     = 256,
   parameter int unsigned X0       = 76,
   parameter int unsigned Y0       = 116,
   parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
   parameter logic [23:0] BG_COLOR = 24'h000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [19:0] fb_addr,
   input  logic [7:0]  hh,
   input  logic [7:0]  mm,
   input  logic [7:0]  ss,
   output logic [8:0]  CR_A,
   input  logic [12:0] CR_Q,
   output logic [19:0] IM_A,
   output logic [23:0] IM_D,
   output logic        IM_WEN,
   output logic        busy,
   output logic        done
);

   localparam logic [19:0] ORIGIN = 20'(Y0 * FB_W + X0);
   localparam logic [19:0] PITCH  = 20'(FB_W);
`ifdef TIME_OVERLAY_OPAQUE_EN
   localparam logic OPAQUE = 1'b1;
`else
   localparam logic OPAQUE = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, REQ, CAP, PIX, DONE} state_t;

   // ROM row address of character c, glyph row r; colons are fixed, bad BCD digits render blank.
   function automatic logic [8:0] glyph_addr(input logic [2:0] c, input logic [4:0] r,
                                            input logic [7:0] h, input logic [7:0] m,
                                            input logic [7:0] s);
      logic [3:0] n;
      logic [3:0] g;
      logic       is_colon;
      n        = 4'd0;
      is_colon = 1'b0;
      case (c)
         3'd0:    n = h[7:4];
         3'd1:    n = h[3:0];
         3'd3:    n = m[7:4];
         3'd4:    n = m[3:0];
         3'd6:    n = s[7:4];
         3'd7:    n = s[3:0];
         default: is_colon = 1'b1;
      endcase
      if (is_colon)        g = 4'd10;
      else if (n > 4'd9)   g = 4'd11;
      else                 g = n;
      return {1'b0, g, 4'b0} + {2'b0, g, 3'b0} + {4'b0, r};
   endfunction

   state_t      state_q, state_d;
   logic [8:0]  cr_a_q, cr_a_d;
   logic [19:0] im_a_q, im_a_d;
   logic [23:0] im_d_q, im_d_d;
   logic        im_wen_q, im_wen_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [7:0]  hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
   logic [19:0] row_base_q, row_base_d;
   logic [19:0] nxt_a_q, nxt_a_d;
   logic [4:0]  r_q, r_d;
   logic [2:0]  c_q, c_d;
   logic [3:0]  p_q, p_d;
   logic [12:0] shift_q, shift_d;
   logic        pix_bit;
   logic        pix_emit;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
      state_d    = state_q;
      cr_a_d     = cr_a_q;
      im_a_d     = im_a_q;
      im_d_d     = im_d_q;
      im_wen_d   = 1'b1;
      busy_d     = busy_q;
      done_d     = 1'b0;
      hh_d       = hh_q;
      mm_d       = mm_q;
      ss_d       = ss_q;
      row_base_d = row_base_q;
      nxt_a_d    = nxt_a_q;
      r_d        = r_q;
      c_d        = c_q;
      p_d        = p_q;
      shift_d    = shift_q;
      pix_bit    = 1'b0;
      pix_emit   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = REQ;
               busy_d     = 1'b1;
               hh_d       = hh;
               mm_d       = mm;
               ss_d       = ss;
               row_base_d = fb_addr + ORIGIN;
               nxt_a_d    = fb_addr + ORIGIN;
               r_d        = 5'd0;
               c_d        = 3'd0;
               cr_a_d     = glyph_addr(3'd0, 5'd0, hh, mm, ss);
            end
         end
         REQ: state_d = CAP;
         CAP: begin
            // ROM data is valid now; pixel 0 goes straight out, the rest queue in the shifter.
            pix_bit  = CR_Q[12];
            pix_emit = 1'b1;
            shift_d  = {CR_Q[11:0], 1'b0};
            p_d      = 4'd0;
            state_d  = PIX;
         end
         PIX: begin
            if (p_q != 4'd12) begin
               pix_bit  = shift_q[12];
               pix_emit = 1'b1;
               shift_d  = {shift_q[11:0], 1'b0};
               p_d      = p_q + 4'd1;
            end else if (c_q == 3'd7 && r_q == 5'd23) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               if (c_q == 3'd7) begin
                  r_d        = r_q + 5'd1;
                  c_d        = 3'd0;
                  row_base_d = row_base_q + PITCH;
                  nxt_a_d    = row_base_q + PITCH;
               end else begin
                  c_d = c_q + 3'd1;
               end
               cr_a_d  = glyph_addr(c_d, r_d, hh_q, mm_q, ss_q);
               state_d = REQ;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Characters are adjacent, so within a row the address simply counts up.
      if (pix_emit) begin
         im_a_d   = nxt_a_q;
         nxt_a_d  = nxt_a_q + 20'd1;
         im_d_d   = pix_bit ? FG_COLOR : BG_COLOR;
         im_wen_d = ~(pix_bit | OPAQUE);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; the async reset aborts any render.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cr_a_q     <= '0;
         im_a_q     <= '0;
         im_d_q     <= '0;
         im_wen_q   <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         hh_q       <= '0;
         mm_q       <= '0;
         ss_q       <= '0;
         row_base_q <= '0;
         nxt_a_q    <= '0;
         r_q        <= '0;
         c_q        <= '0;
         p_q        <= '0;
         shift_q    <= '0;
      end else begin
         state_q    <= state_d;
         cr_a_q     <= cr_a_d;
         im_a_q     <= im_a_d;
         im_d_q     <= im_d_d;
         im_wen_q   <= im_wen_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         hh_q       <= hh_d;
         mm_q       <= mm_d;
         ss_q       <= ss_d;
         row_base_q <= row_base_d;
         nxt_a_q    <= nxt_a_d;
         r_q        <= r_d;
         c_q        <= c_d;
         p_q        <= p_d;
         shift_q    <= shift_d;
      end
   end

   assign CR_A   = cr_a_q;
   assign IM_A   = im_a_q;
   assign IM_D   = im_d_q;
   assign IM_WEN = im_wen_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_time_overlay_render.sv
// Self-checking bench for time_overlay_render: reference pixel model feeds a write scoreboard.
// Build with TIME_OVERLAY_OPAQUE_EN defined to check the opaque variant.
module tb_time_overlay_render;

   localparam int          FB_W = 256;
   localparam int          X0   = 76;
   localparam int          Y0   = 116;
   localparam logic [23:0] FG   = 24'hFFFFFF;
   localparam logic [23:0] BG   = 24'h000000;
   localparam int          LAT  = 2881;

   logic        clk     = 1'b0;
   logic        reset   = 1'b0;
   logic        start   = 1'b0;
   logic [19:0] fb_addr = '0;
   logic [7:0]  hh = '0, mm = '0, ss = '0;
   logic [8:0]  cr_a;
   logic [12:0] cr_q = '0;
   logic [19:0] im_a;
   logic [23:0] im_d;
   logic        im_wen, busy, done;

   int vectors     = 0;
   int miscompares = 0;
   int writes      = 0;
   logic [43:0] exp_q[$];

   always #5 clk = ~clk;

   time_overlay_render dut (
      .clk(clk), .reset(reset), .start(start), .fb_addr(fb_addr),
      .hh(hh), .mm(mm), .ss(ss), .CR_A(cr_a), .CR_Q(cr_q),
      .IM_A(im_a), .IM_D(im_d), .IM_WEN(im_wen), .busy(busy), .done(done)
   );

   // Character ROM contents: pseudo-random rows for glyphs 0-10, glyph 11 (blank) all zero.
   function automatic logic [12:0] rom_fn(input logic [8:0] a);
      logic [31:0] x;
      if (a >= 9'd264) return 13'd0;
      x = 32'(a) * 32'd40503 + 32'd977;
      x = x ^ (x >> 9);
      return x[20:8];
   endfunction

   always @(posedge clk) cr_q <= rom_fn(cr_a);

   // Scoreboard: every DUT write is matched against the next expected {address, data}.
   always @(negedge clk) begin
      if (reset === 1'b1 && im_wen === 1'b0) begin
         writes++;
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write: got addr=%h data=%h, none expected", im_a, im_d);
         end else begin
            logic [43:0] e;
            e = exp_q.pop_front();
            if ({im_a, im_d} !== e) begin
               miscompares++;
               $display("FAIL write: got addr=%h data=%h, want addr=%h data=%h",
                        im_a, im_d, e[43:24], e[23:0]);
            end
         end
      end
   end

   task automatic push_model(input logic [19:0] fb, input logic [7:0] h, input logic [7:0] m,
                             input logic [7:0] s, output int n);
      logic [3:0]  nib [8];
      logic [3:0]  g;
      logic [12:0] row;
      logic [19:0] a;
      n = 0;
      nib[0] = h[7:4]; nib[1] = h[3:0]; nib[2] = 4'd0; nib[3] = m[7:4];
      nib[4] = m[3:0]; nib[5] = 4'd0;   nib[6] = s[7:4]; nib[7] = s[3:0];
      for (int r = 0; r < 24; r++) begin
         for (int c = 0; c < 8; c++) begin
            if (c == 2 || c == 5)   g = 4'd10;
            else if (nib[c] > 4'd9) g = 4'd11;
            else                    g = nib[c];
            row = rom_fn(9'(int'(g) * 24 + r));
            for (int p = 0; p < 13; p++) begin
               a = 20'(32'(fb) + (Y0 + r) * FB_W + X0 + 13 * c + p);
`ifdef TIME_OVERLAY_OPAQUE_EN
               exp_q.push_back({a, (row[12-p] ? FG : BG)});
               n++;
`else
               if (row[12-p]) begin
                  exp_q.push_back({a, FG});
                  n++;
               end
`endif
            end
         end
      end
   endtask

   task automatic kick(input logic [19:0] fb, input logic [7:0] h, input logic [7:0] m,
                       input logic [7:0] s, output int n);
      @(negedge clk);
      fb_addr = fb; hh = h; mm = m; ss = s;
      start   = 1'b1;
      writes  = 0;
      push_model(fb, h, m, s, n);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         start   = 1'($urandom_range(0, 1));
         fb_addr = 20'($urandom);
         hh = 8'($urandom); mm = 8'($urandom); ss = 8'($urandom);
         vectors++;
         if ({im_a, im_d, im_wen, cr_a, busy, done} !== {20'd0, 24'd0, 1'b1, 9'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values: got a=%h d=%h wen=%b cra=%0d busy=%b done=%b",
                     im_a, im_d, im_wen, cr_a, busy, done);
         end
      end
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || im_wen !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release_idle: got busy=%b wen=%b, want 0/1", busy, im_wen);
      end
   endtask

   task automatic test_normal;
      int n;
      int done_seen;
      kick(20'h01000, 8'h12, 8'h34, 8'h56, n);
      done_seen = 0;
      for (int k = 1; k <= LAT + 5; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0;
            fb_addr = 20'h55555; hh = 8'h99; mm = 8'h88; ss = 8'h77;
            vectors++;
            if (cr_a !== 9'd24) begin
               miscompares++;
               $display("FAIL normal_cra_c1: got %0d want 24", cr_a);
            end
         end
         if (k == 3) begin
            vectors++;
            if (im_a !== 20'(20'h01000 + 116 * 256 + 76)) begin
               miscompares++;
               $display("FAIL normal_first_addr: got %h want %h", im_a, 20'(20'h01000 + 116 * 256 + 76));
            end
         end
         if (k == 31) begin
            vectors++;
            if (cr_a !== 9'd240) begin
               miscompares++;
               $display("FAIL normal_cra_colon: got %0d want 240", cr_a);
            end
         end
         if (done === 1'b1) done_seen++;
         vectors++;
         if (busy !== (k <= LAT) || done !== (k == LAT)) begin
            miscompares++;
            $display("FAIL normal_busy_done cycle %0d: got busy=%b done=%b", k, busy, done);
         end
      end
`ifdef TIME_OVERLAY_OPAQUE_EN
      vectors++;
      if (n != 2496 || writes != 2496) begin
         miscompares++;
         $display("FAIL normal_opaque_count: got %0d model %0d want 2496", writes, n);
      end
`endif
      vectors++;
      if (writes != n || exp_q.size() != 0 || done_seen != 1) begin
         miscompares++;
         $display("FAIL normal_totals: got writes=%0d leftover=%0d dones=%0d want %0d/0/1",
                  writes, exp_q.size(), done_seen, n);
      end
   endtask

   task automatic test_invalid_digit;
      int n;
      int b;
      kick(20'h20000, 8'h3A, 8'h07, 8'h59, n);
      for (int k = 1; k <= LAT + 2; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (k <= LAT - 1) begin
            b = (k - 1) / 15;
            if ((b % 8) == 1 && ((k - 1) % 15) == 0) begin
               vectors++;
               if (cr_a !== 9'(264 + b / 8)) begin
                  miscompares++;
                  $display("FAIL invalid_cra row %0d: got %0d want %0d", b / 8, cr_a, 264 + b / 8);
               end
            end
`ifdef TIME_OVERLAY_OPAQUE_EN
            if ((b % 8) == 1 && im_wen === 1'b0) begin
               vectors++;
               if (im_d !== BG) begin
                  miscompares++;
                  $display("FAIL invalid_bg cycle %0d: got %h want %h", k, im_d, BG);
               end
            end
`else
            if ((b % 8) == 1) begin
               vectors++;
               if (im_wen !== 1'b1) begin
                  miscompares++;
                  $display("FAIL invalid_write cycle %0d: got wen=%b want 1", k, im_wen);
               end
            end
`endif
         end
      end
      vectors++;
      if (writes != n || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL invalid_totals: got writes=%0d leftover=%0d want %0d/0", writes, exp_q.size(), n);
      end
   endtask

   task automatic test_wrap;
      int n;
      int done_at;
      logic saw_low;
      kick(20'hF8000, 8'h23, 8'h59, 8'h58, n);
      done_at = -1;
      saw_low = 1'b0;
      for (int k = 1; k <= LAT + 3; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (k == 3) begin
            vectors++;
            if (im_a !== 20'hFF44C) begin
               miscompares++;
               $display("FAIL wrap_first_addr: got %h want FF44C", im_a);
            end
         end
         if (im_wen === 1'b0 && im_a < 20'h08000) saw_low = 1'b1;
         if (done === 1'b1 && done_at < 0) done_at = k;
      end
      vectors++;
      if (saw_low !== 1'b1 || done_at != LAT || exp_q.size() != 0 || writes != n) begin
         miscompares++;
         $display("FAIL wrap: got low_write=%b done_at=%0d leftover=%0d writes=%0d want 1/%0d/0/%0d",
                  saw_low, done_at, exp_q.size(), writes, LAT, n);
      end
   endtask

   task automatic test_start_ignored;
      int n;
      int dones;
      kick(20'h00400, 8'h01, 8'h02, 8'h03, n);
      dones = 0;
      for (int k = 1; k <= LAT + 20; k++) begin
         @(negedge clk);
         start = (k == 100 || k == LAT) ? 1'b1 : 1'b0;
         if (k == 100) begin
            fb_addr = 20'h12345; hh = 8'h11; mm = 8'h11; ss = 8'h11;
         end
         if (done === 1'b1) dones++;
         if (k > LAT + 1) begin
            vectors++;
            if (busy !== 1'b0) begin
               miscompares++;
               $display("FAIL ignored_restart cycle %0d: got busy=%b want 0", k, busy);
            end
         end
      end
      vectors++;
      if (dones != 1 || writes != n || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL ignored_totals: got dones=%0d writes=%0d leftover=%0d want 1/%0d/0",
                  dones, writes, exp_q.size(), n);
      end
   endtask

   task automatic test_reset_mid;
      int n;
      int w0;
      kick(20'h30000, 8'h08, 8'h88, 8'h18, n);
      for (int k = 1; k <= 500; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
      end
      reset = 1'b0;
      #1;
      exp_q.delete();
      w0 = writes;
      vectors++;
      if (im_wen !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_abort: got wen=%b busy=%b done=%b want 1/0/0", im_wen, busy, done);
      end
      repeat (4) @(negedge clk);
      reset = 1'b1;
      repeat (300) @(negedge clk);
      vectors++;
      if (writes != w0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_quiet: got writes=%0d busy=%b want %0d/0", writes, busy, w0);
      end
   endtask

   task automatic test_back_to_back;
      int n1;
      int n2;
      int done_at;
      kick(20'h40000, 8'h09, 8'h30, 8'h00, n1);
      for (int k = 1; k <= LAT + 1; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
      end
      vectors++;
      if (writes != n1 || exp_q.size() != 0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_first: got writes=%0d leftover=%0d busy=%b want %0d/0/0",
                  writes, exp_q.size(), busy, n1);
      end
      fb_addr = 20'h50000; hh = 8'h19; mm = 8'h45; ss = 8'h27;
      start   = 1'b1;
      writes  = 0;
      push_model(fb_addr, hh, mm, ss, n2);
      done_at = -1;
      for (int k = 1; k <= LAT + 3; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (k == 1) begin
            vectors++;
            if (busy !== 1'b1 || cr_a !== 9'd24) begin
               miscompares++;
               $display("FAIL b2b_accept: got busy=%b cra=%0d want 1/24", busy, cr_a);
            end
         end
         if (done === 1'b1 && done_at < 0) done_at = k;
      end
      vectors++;
      if (done_at != LAT || writes != n2 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL b2b_second: got done_at=%0d writes=%0d leftover=%0d want %0d/%0d/0",
                  done_at, writes, exp_q.size(), LAT, n2);
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_invalid_digit();
      test_wrap();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
